obi_mem_arbiter: RTL



---
 rtl/obi_arb_pkg.sv | 30 +++
 rtl/obi_arb_id_fifo.sv | 75 +++++++
 rtl/obi_mem_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/obi_arb_pkg.sv
// Shared types for the two-port OBI memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package obi_arb_pkg;

  localparam int unsigned DEFAULT_MAX_OUTSTANDING = 2;
  localparam int unsigned DEFAULT_ADDR_W          = 32;
  localparam int unsigned DEFAULT_DATA_W          = 32;

  // Requester identity; also the 1-bit payload of the outstanding-ID FIFO.
  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } port_id_e;

  // Address-phase bundle at the default bus width.
  typedef struct packed {
    logic [DEFAULT_ADDR_W-1:0]   addr;
    logic                        we;
    logic [DEFAULT_DATA_W/8-1:0] be;
    logic [DEFAULT_DATA_W-1:0]   wdata;
  } obi_req_t;

  // Response-phase bundle at the default bus width.
  typedef struct packed {
    logic [DEFAULT_DATA_W-1:0] rdata;
    logic                      err;
  } obi_rsp_t;

endpackage

// File: rtl/obi_arb_id_fifo.sv
// In-order FIFO of 1-bit requester IDs for transactions awaiting a response.
// Latency: head is combinational; when empty a same-cycle push bypasses to head.
// Backpressure: none internally; caller only pushes with space (full+pop is legal).
module obi_arb_id_fifo #(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             push_id_i,
  input  logic             pop_i,
  output logic             head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, empty, do_push, do_pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // An empty FIFO with push and pop together passes the ID straight through
  // and keeps no state; otherwise push needs a free slot or a same-cycle pop.
  assign do_push = push_i && !(empty && pop_i) && (!full || pop_i);
  assign do_pop  = pop_i && !empty;

  assign head_o  = empty ? push_id_i : mem_q[rptr_q];
  assign count_o = count_q;
  assign empty_o = empty;

  // Next-state for storage, pointers (wrapping at DEPTH) and occupancy.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[wptr_q] = push_id_i;
      wptr_d        = (wptr_q == LAST_PTR) ? '0 : wptr_q + 1'b1;
    end
    if (do_pop) begin
      rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; reset empties the FIFO.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/obi_mem_arbiter.sv
// Shares one OBI memory between instruction (port 0) and data (port 1) requesters.
// Latency: zero added cycles on grant and response paths (both combinational).
// Backpressure: requests withheld when MAX_OUTSTANDING unanswered, unless a response pops this cycle.
// Optional: define OBI_ARB_RR_EN for round-robin; default is fixed priority (data over instr).
module obi_mem_arbiter
  import obi_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  // port 0: instruction fetch
  input  logic                s0_req_i,
  output logic                s0_gnt_o,
  input  logic [ADDR_W-1:0]   s0_addr_i,
  input  logic                s0_we_i,
  input  logic [DATA_W/8-1:0] s0_be_i,
  input  logic [DATA_W-1:0]   s0_wdata_i,
  output logic                s0_rvalid_o,
  output logic [DATA_W-1:0]   s0_rdata_o,
  output logic                s0_err_o,
  // port 1: data load/store
  input  logic                s1_req_i,
  output logic                s1_gnt_o,
  input  logic [ADDR_W-1:0]   s1_addr_i,
  input  logic                s1_we_i,
  input  logic [DATA_W/8-1:0] s1_be_i,
  input  logic [DATA_W-1:0]   s1_wdata_i,
  output logic                s1_rvalid_o,
  output logic [DATA_W-1:0]   s1_rdata_o,
  output logic                s1_err_o,
  // memory side
  output logic                m_req_o,
  input  logic                m_gnt_i,
  output logic [ADDR_W-1:0]   m_addr_o,
  output logic                m_we_o,
  output logic [DATA_W/8-1:0] m_be_o,
  output logic [DATA_W-1:0]   m_wdata_o,
  input  logic                m_rvalid_i,
  input  logic [DATA_W-1:0]   m_rdata_i,
  input  logic                m_err_i,
  output logic                unexp_rvalid_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  // Address-phase bundle at this instance's widths.
  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic                we;
    logic [DATA_W/8-1:0] be;
    logic [DATA_W-1:0]   wdata;
  } req_t;

  req_t       s0_req, s1_req, sel_req;
  logic [0:0] state_q, state_d;
  port_id_e   sel_q, sel_d, sel;
  logic       unexp_q, unexp_d;
  logic       space, m_req, handshake, rsp_ok;
  logic       fifo_head, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  assign s0_req = '{addr: s0_addr_i, we: s0_we_i, be: s0_be_i, wdata: s0_wdata_i};
  assign s1_req = '{addr: s1_addr_i, we: s1_we_i, be: s1_be_i, wdata: s1_wdata_i};

  // A response in this cycle frees a slot, so a full tracker can still grant.
  assign space     = (fifo_count < MAX_CNT) || m_rvalid_i;
  assign m_req     = space && (s0_req_i || s1_req_i);
  assign handshake = m_req && m_gnt_i;

`ifdef OBI_ARB_RR_EN
  port_id_e rr_q, rr_d;

  // Remember the most recently granted port.
  always_comb begin
    rr_d = rr_q;
    if (handshake) rr_d = sel;
  end

  // Round-robin history register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_q <= PORT_INSTR;
    else         rr_q <= rr_d;
  end
`endif

  // Pick the port driving the address phase; a stalled request stays selected.
  always_comb begin
    sel = PORT_DATA;
    if (state_q == ST_LOCKED) begin
      sel = sel_q;
    end else if (s0_req_i && s1_req_i) begin
`ifdef OBI_ARB_RR_EN
      sel = (rr_q == PORT_DATA) ? PORT_INSTR : PORT_DATA;
`else
      sel = PORT_DATA;
`endif
    end else if (s0_req_i) begin
      sel = PORT_INSTR;
    end
  end

  assign sel_req = (sel == PORT_DATA) ? s1_req : s0_req;

  // Lock onto the selection while the memory stalls the address phase.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      ST_UNLOCKED: begin
        if (m_req && !m_gnt_i) begin
          state_d = ST_LOCKED;
          sel_d   = sel;
        end
      end
      ST_LOCKED: begin
        if (handshake) state_d = ST_UNLOCKED;
      end
      default: state_d = ST_UNLOCKED;
    endcase
  end

  // A response is routable if something is outstanding or is pushed this
  // same cycle; anything else is a stray and latches the sticky flag.
  assign rsp_ok = m_rvalid_i && (!fifo_empty || handshake);

  // Sticky stray-response flag, cleared only by reset.
  always_comb begin
    unexp_d = unexp_q;
    if (m_rvalid_i && fifo_empty && !handshake) unexp_d = 1'b1;
  end

  // Lock state, locked selection and stray-response flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_UNLOCKED;
      sel_q   <= PORT_INSTR;
      unexp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      unexp_q <= unexp_d;
    end
  end

  obi_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (handshake),
    .push_id_i (sel),
    .pop_i     (rsp_ok),
    .head_o    (fifo_head),
    .count_o   (fifo_count),
    .empty_o   (fifo_empty)
  );

  // Outputs are forced low while reset is asserted.
  assign m_req_o     = rst_ni && m_req;
  assign m_addr_o    = rst_ni ? sel_req.addr  : '0;
  assign m_we_o      = rst_ni && sel_req.we;
  assign m_be_o      = rst_ni ? sel_req.be    : '0;
  assign m_wdata_o   = rst_ni ? sel_req.wdata : '0;

  assign s0_gnt_o    = rst_ni && handshake && (sel == PORT_INSTR);
  assign s1_gnt_o    = rst_ni && handshake && (sel == PORT_DATA);

  // Only rvalid is steered; rdata and err go to both ports.
  assign s0_rvalid_o = rst_ni && rsp_ok && (fifo_head == 1'b0);
  assign s1_rvalid_o = rst_ni && rsp_ok && (fifo_head == 1'b1);
  assign s0_rdata_o  = rst_ni ? m_rdata_i : '0;
  assign s1_rdata_o  = rst_ni ? m_rdata_i : '0;
  assign s0_err_o    = rst_ni && m_err_i;
  assign s1_err_o    = rst_ni && m_err_i;

  assign unexp_rvalid_o = rst_ni && unexp_q;

endmodule
